pwm_multichannel: RTL and testbench

PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

---
 rtl/pwm_multichannel.sv | 180 ++++++++++++++++++
 tb/tb_pwm_multichannel.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM on one shared carrier with shadowed period/mode/compare and complementary A/B outputs.
// Optional dead-time insertion is built when the macro PWM_DEADTIME_EN is defined.
module pwm_multichannel #(
   parameter int CNT_W = 16,
   parameter int NCH   = 3,
   parameter int DT_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [7:0]           prescale,
   input  logic [CNT_W-1:0]     period,
   input  logic [1:0]           count_mode,
   input  logic [1:0]           load_mode,
   input  logic [NCH*CNT_W-1:0] compare,
   input  logic [DT_W-1:0]      dt_a,
   input  logic [DT_W-1:0]      dt_b,
   input  logic [NCH-1:0]       pol_a,
   input  logic [NCH-1:0]       pol_b,
   output logic [NCH-1:0]       pwm_a,
   output logic [NCH-1:0]       pwm_b,
   output logic [CNT_W-1:0]     carrier,
   output logic                 evt
);

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_UPDN = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [7:0]           r_pre;
   logic [CNT_W-1:0]     r_carrier;
   logic                 r_dir_up;
   logic [CNT_W-1:0]     r_period_sh;
   logic [1:0]           r_mode_sh;
   logic [NCH*CNT_W-1:0] r_cmp_sh;
   logic [NCH-1:0]       r_master;
   logic [NCH-1:0]       r_raw_a;
   logic [NCH-1:0]       r_raw_b;
   logic                 r_evt;

   logic [CNT_W-1:0]     w_next;
   logic                 w_next_dir_up;
   logic                 w_tick;
   logic                 w_zero_evt;
   logic                 w_per_evt;
   logic                 w_load;

   assign w_tick = en && (r_pre >= prescale);

   always_comb begin
      w_next        = r_carrier;
      w_next_dir_up = r_dir_up;
      case (r_mode_sh)
         MODE_UP:   w_next = (r_carrier >= r_period_sh) ? '0 : r_carrier + CNT_ONE;
         MODE_DOWN: w_next = ((r_carrier == '0) || (r_carrier > r_period_sh)) ? r_period_sh
                                                                              : r_carrier - CNT_ONE;
         MODE_UPDN: begin
            if (r_period_sh == '0) begin
               w_next        = '0;
               w_next_dir_up = 1'b1;
            end else if (r_dir_up) begin
               if (r_carrier >= r_period_sh) begin
                  w_next        = r_period_sh - CNT_ONE;
                  w_next_dir_up = 1'b0;
               end else begin
                  w_next = r_carrier + CNT_ONE;
               end
            end else if (r_carrier == '0) begin
               w_next        = CNT_ONE;
               w_next_dir_up = 1'b1;
            end else begin
               w_next = r_carrier - CNT_ONE;
            end
         end
         default: w_next = r_carrier;
      endcase
   end

   // Events fire on the tick that moves the carrier onto zero / period; a held carrier never fires.
   assign w_zero_evt = w_tick && (r_mode_sh != MODE_HOLD) && (w_next == '0);
   assign w_per_evt  = w_tick && (r_mode_sh != MODE_HOLD) && (w_next == r_period_sh);
   assign w_load     = !en || (load_mode == 2'b00) ||
                       (load_mode[0] && w_zero_evt) || (load_mode[1] && w_per_evt);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pre       <= '0;
         r_carrier   <= '0;
         r_dir_up    <= 1'b1;
         r_period_sh <= '0;
         r_mode_sh   <= MODE_UP;
         r_cmp_sh    <= '0;
         r_evt       <= 1'b0;
      end else begin
         r_pre <= (!en || w_tick) ? 8'd0 : r_pre + 8'd1;
         if (!en) begin
            r_carrier <= (r_mode_sh == MODE_DOWN) ? r_period_sh : '0;
            r_dir_up  <= 1'b1;
         end else if (w_tick) begin
            r_carrier <= w_next;
            r_dir_up  <= w_next_dir_up;
         end
         if (w_load) begin
            r_period_sh <= period;
            r_mode_sh   <= count_mode;
            r_cmp_sh    <= compare;
         end
         r_evt <= en && ((load_mode == 2'b00) ? w_zero_evt : w_load);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_master <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_master[i] <= (r_carrier < r_cmp_sh[i*CNT_W +: CNT_W]);
         end
      end
   end

`ifdef PWM_DEADTIME_EN
   localparam logic [DT_W-1:0] DT_ONE = {{(DT_W-1){1'b0}}, 1'b1};
   logic [DT_W-1:0] r_dt_cnt_a [NCH];
   logic [DT_W-1:0] r_dt_cnt_b [NCH];

   // Each side counts how long its level has been asserted; it only rises once the count reaches its dead time.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_raw_a <= '0;
         r_raw_b <= '0;
         for (int i = 0; i < NCH; i++) begin
            r_dt_cnt_a[i] <= '0;
            r_dt_cnt_b[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (!en) begin
               r_raw_a[i]    <= 1'b0;
               r_raw_b[i]    <= 1'b0;
               r_dt_cnt_a[i] <= '0;
               r_dt_cnt_b[i] <= '0;
            end else if (r_master[i]) begin
               r_raw_b[i]    <= 1'b0;
               r_dt_cnt_b[i] <= '0;
               if (r_dt_cnt_a[i] >= dt_a) r_raw_a[i] <= 1'b1;
               else                       r_dt_cnt_a[i] <= r_dt_cnt_a[i] + DT_ONE;
            end else begin
               r_raw_a[i]    <= 1'b0;
               r_dt_cnt_a[i] <= '0;
               if (r_dt_cnt_b[i] >= dt_b) r_raw_b[i] <= 1'b1;
               else                       r_dt_cnt_b[i] <= r_dt_cnt_b[i] + DT_ONE;
            end
         end
      end
   end
`else
   logic w_unused_dt;
   assign w_unused_dt = ^{dt_a, dt_b};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_raw_a <= '0;
         r_raw_b <= '0;
      end else begin
         r_raw_a <= en ? r_master  : '0;
         r_raw_b <= en ? ~r_master : '0;
      end
   end
`endif

   // Polarity stays combinational so the outputs show pol_a/pol_b during reset.
   assign pwm_a   = r_raw_a ^ pol_a;
   assign pwm_b   = r_raw_b ^ pol_b;
   assign carrier = r_carrier;
   assign evt     = r_evt;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: vector table of duty/event counts plus hand-written timing sequences.
module tb_pwm_multichannel;
   localparam int CNT_W = 16;
   localparam int NCH   = 3;
   localparam int DT_W  = 8;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 en;
   logic [7:0]           prescale;
   logic [CNT_W-1:0]     period;
   logic [1:0]           count_mode;
   logic [1:0]           load_mode;
   logic [NCH*CNT_W-1:0] compare;
   logic [DT_W-1:0]      dt_a;
   logic [DT_W-1:0]      dt_b;
   logic [NCH-1:0]       pol_a;
   logic [NCH-1:0]       pol_b;
   logic [NCH-1:0]       pwm_a;
   logic [NCH-1:0]       pwm_b;
   logic [CNT_W-1:0]     carrier;
   logic                 evt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pwm_multichannel #(.CNT_W(CNT_W), .NCH(NCH), .DT_W(DT_W)) dut (
      .clk(clk), .reset(reset), .en(en), .prescale(prescale), .period(period),
      .count_mode(count_mode), .load_mode(load_mode), .compare(compare),
      .dt_a(dt_a), .dt_b(dt_b), .pol_a(pol_a), .pol_b(pol_b),
      .pwm_a(pwm_a), .pwm_b(pwm_b), .carrier(carrier), .evt(evt)
   );

   typedef struct {
      int         mode;
      int         ps;
      int         per;
      int         c0, c1, c2;
      logic [2:0] pa, pb;
      int         win;
      int         ea0, ea1, ea2;
      int         eb0, eb1, eb2;
      int         ee;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic setup(input int mode, input int lmode, input int ps, input int per,
                        input int c0, input int c1, input int c2,
                        input logic [2:0] pa, input logic [2:0] pb, input int da, input int db);
      @(negedge clk);
      en         = 1'b0;
      count_mode = 2'(mode);
      load_mode  = 2'(lmode);
      prescale   = 8'(ps);
      period     = 16'(per);
      compare    = {16'(c2), 16'(c1), 16'(c0)};
      pol_a      = pa;
      pol_b      = pb;
      dt_a       = 8'(da);
      dt_b       = 8'(db);
      repeat (3) @(negedge clk);
      en = 1'b1;
   endtask

   // Bounded wait; an expired bound shows up as a failed carrier comparison.
   task automatic wait_carrier(input int val, input string name);
      int k = 0;
      while (carrier !== 16'(val) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(carrier), 32'(val));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      int ca[3];
      int cb[3];
      int ce;
      int ea[3];
      int eb[3];
      int c;
      int cnt_old;
      int cnt_new;
      int prev;
      int k;
      logic [15:0] v;
      logic exp_a;
      int exp_seq[9];

      //         mode ps per  c0 c1 c2  pa      pb      win  a0 a1 a2  b0 b1 b2  evt
      vecs[0] = '{0, 0, 9,  5, 2, 9,  3'b000, 3'b100, 20, 10, 4, 18, 10, 16, 18, 2};
      vecs[1] = '{0, 0, 9,  2, 5, 9,  3'b010, 3'b000, 20, 4, 10, 18, 16, 10, 2,  2};
      vecs[2] = '{0, 0, 9,  2, 7, 9,  3'b010, 3'b000, 20, 4, 6,  18, 16, 6,  2,  2};
      // up-down period 4: carrier 1,0,1 are below 2, so 3 of every 8 ticks.
      vecs[3] = '{2, 0, 4,  2, 0, 5,  3'b000, 3'b000, 16, 6, 0,  16, 10, 16, 0,  2};
      vecs[4] = '{1, 0, 9,  3, 10, 0, 3'b000, 3'b000, 20, 6, 20, 0,  14, 0,  20, 2};
      vecs[5] = '{0, 3, 4,  2, 4, 5,  3'b000, 3'b000, 40, 16, 32, 40, 24, 8, 0,  2};
      vecs[6] = '{0, 0, 0,  0, 1, 3,  3'b000, 3'b000, 10, 0, 10, 10, 10, 0,  0,  10};
      vecs[7] = '{3, 0, 9,  5, 0, 1,  3'b000, 3'b000, 10, 10, 0, 10, 0,  10, 0,  0};

      // Reset state: outputs follow polarity, carrier and evt cleared.
      reset      = 1'b0;
      en         = 1'b0;
      prescale   = 8'd0;
      period     = 16'd9;
      count_mode = 2'b00;
      load_mode  = 2'b00;
      compare    = {16'd9, 16'd2, 16'd5};
      dt_a       = 8'd0;
      dt_b       = 8'd0;
      pol_a      = 3'b101;
      pol_b      = 3'b011;
      #2;
      check("reset pwm_a", 32'(pwm_a), 32'(3'b101));
      check("reset pwm_b", 32'(pwm_b), 32'(3'b011));
      check("reset carrier", 32'(carrier), 32'd0);
      check("reset evt", 32'(evt), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      for (int n = 0; n < 8; n++) begin
         setup(vecs[n].mode, 0, vecs[n].ps, vecs[n].per, vecs[n].c0, vecs[n].c1, vecs[n].c2,
               vecs[n].pa, vecs[n].pb, 0, 0);
         repeat (30) @(negedge clk);
         ca = '{0, 0, 0};
         cb = '{0, 0, 0};
         ce = 0;
         repeat (vecs[n].win) begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++) begin
               ca[ch] += int'(pwm_a[ch]);
               cb[ch] += int'(pwm_b[ch]);
            end
            ce += int'(evt);
         end
         ea = '{vecs[n].ea0, vecs[n].ea1, vecs[n].ea2};
         eb = '{vecs[n].eb0, vecs[n].eb1, vecs[n].eb2};
         for (int ch = 0; ch < NCH; ch++) begin
            check($sformatf("vec%0d a%0d high count", n, ch), 32'(ca[ch]), 32'(ea[ch]));
            check($sformatf("vec%0d b%0d high count", n, ch), 32'(cb[ch]), 32'(eb[ch]));
         end
         check($sformatf("vec%0d evt count", n), 32'(ce), 32'(vecs[n].ee));
      end

      // Up mode, period 9, compare 5: output lags carrier by 2 clk, so A is high at carrier 2..6.
      setup(0, 0, 0, 9, 5, 0, 0, 3'b000, 3'b000, 0, 0);
      repeat (30) @(negedge clk);
      wait_carrier(0, "wave align carrier");
      for (int i = 0; i < 10; i++) begin
         c     = int'(carrier);
         exp_a = (c >= 2) && (c <= 6);
         check($sformatf("wave a0 c=%0d", c), 32'(pwm_a[0]), 32'(exp_a));
         check($sformatf("wave b0 c=%0d", c), 32'(pwm_b[0]), 32'(!exp_a));
         check($sformatf("wave evt c=%0d", c), 32'(evt), 32'(c == 0));
         @(negedge clk);
      end

      // Up-down carrier trajectory from enable.
      exp_seq = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
      setup(2, 0, 0, 4, 2, 0, 0, 3'b000, 3'b000, 0, 0);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("updown carrier step %0d", i), 32'(carrier), 32'(exp_seq[i]));
         @(negedge clk);
      end

      // Load at zero: compare 5->8 mid-period takes effect only after the wrap.
      setup(0, 1, 0, 9, 5, 0, 0, 3'b000, 3'b000, 0, 0);
      repeat (30) @(negedge clk);
      wait_carrier(3, "load align carrier");
      check("load evt before wrap", 32'(evt), 32'd0);
      compare = {16'd0, 16'd0, 16'd8};
      cnt_old = 0;
      cnt_new = 0;
      for (int i = 1; i <= 18; i++) begin
         @(negedge clk);
         if (i >= 2 && i <= 8) cnt_old += int'(pwm_a[0]);
         if (i >= 9) cnt_new += int'(pwm_a[0]);
         if (i == 7) begin
            check("load wrap carrier", 32'(carrier), 32'd0);
            check("load evt at wrap", 32'(evt), 32'd1);
         end
      end
      check("load old duty tail", 32'(cnt_old), 32'd2);
      check("load new duty", 32'(cnt_new), 32'd8);

      // Prescale 3: carrier steps every 4 clk; then async reset at carrier 7.
      setup(0, 0, 3, 9, 5, 0, 0, 3'b110, 3'b001, 0, 0);
      repeat (10) @(negedge clk);
      prev = int'(carrier);
      k    = 0;
      while (int'(carrier) == prev && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("prescale step seen", 32'(k < 10), 32'd1);
      v = carrier;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("prescale hold %0d", i), 32'(carrier), 32'(v));
      end
      @(negedge clk);
      check("prescale advance", 32'(carrier), 32'((int'(v) + 1) % 10));
      wait_carrier(7, "reset align carrier");
      reset = 1'b0;
      #1;
      check("midrun reset pwm_a", 32'(pwm_a), 32'(3'b110));
      check("midrun reset pwm_b", 32'(pwm_b), 32'(3'b001));
      check("midrun reset carrier", 32'(carrier), 32'd0);
      check("midrun reset evt", 32'(evt), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("restart hold %0d", i), 32'(carrier), 32'd0);
      end
      @(negedge clk);
      check("restart first step", 32'(carrier), 32'd1);

`ifdef PWM_DEADTIME_EN
      // Dead time: A high at carrier 5..11, B high at carrier 14..19,0,1.
      setup(0, 0, 0, 19, 10, 0, 0, 3'b000, 3'b000, 3, 2);
      repeat (50) @(negedge clk);
      wait_carrier(0, "dt align carrier");
      for (int i = 0; i < 20; i++) begin
         c = int'(carrier);
         check($sformatf("dt a0 c=%0d", c), 32'(pwm_a[0]), 32'((c >= 5) && (c <= 11)));
         check($sformatf("dt b0 c=%0d", c), 32'(pwm_b[0]), 32'((c >= 14) || (c <= 1)));
         @(negedge clk);
      end
      compare = {16'd0, 16'd0, 16'd2};
      repeat (25) @(negedge clk);
      cnt_new = 0;
      repeat (40) begin
         @(negedge clk);
         cnt_new += int'(pwm_a[0]);
      end
      check("dt short pulse suppressed", 32'(cnt_new), 32'd0);
`else
      // Without dead-time support, dt inputs have no effect on duty.
      setup(0, 0, 0, 9, 5, 0, 0, 3'b000, 3'b000, 5, 7);
      repeat (30) @(negedge clk);
      ca[0] = 0;
      cb[0] = 0;
      repeat (20) begin
         @(negedge clk);
         ca[0] += int'(pwm_a[0]);
         cb[0] += int'(pwm_b[0]);
      end
      check("dt ignored a0", 32'(ca[0]), 32'd10);
      check("dt ignored b0", 32'(cb[0]), 32'd10);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
